// File: rtl/alu_slice_sequencer.sv
// alu_slice_sequencer: multi-word front end for a 16-bit ALU.
// Splits wide requests into 16-bit slices and chains the ALU carry.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_a, req_b          DW-bit operands
//   req_op                {mode, sel[3:0]} passed to the ALU
//   req_cin               active-high carry into slice 0
//   rsp_valid/rsp_ready   response handshake
//   rsp_result, rsp_cout  assembled result, raw top carry
//   busy                  high in ISSUE or RESP
//   alu_*                 drive/return of the 16-bit ALU

module alu_slice_sequencer #(
   parameter int WORDS         = 2,
   parameter int SETTLE_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [16*WORDS-1:0]   req_a,
   input  logic [16*WORDS-1:0]   req_b,
   input  logic [4:0]            req_op,
   input  logic                  req_cin,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [16*WORDS-1:0]   rsp_result,
   output logic                  rsp_cout,
   output logic                  busy,
   output logic [15:0]           alu_a,
   output logic [15:0]           alu_b,
   output logic                  alu_mode,
   output logic [3:0]            alu_sel,
   output logic                  alu_cin_n,
   input  logic [15:0]           alu_result,
   input  logic                  alu_cout_n
);

   localparam int DW = 16 * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] LAST_K = KW'(WORDS - 1);
   localparam logic [2:0] SC = 3'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] res_q;
   logic [4:0]    op_q;
   logic          carry_n_q;
   logic [KW-1:0] k_q;
   logic [2:0]    w_q;
   logic          fire;
   logic          last;
   logic [15:0]   a_slc;
   logic [15:0]   b_slc;

   // fire: the current slice has settled and is captured this edge
   assign fire = (w_q == SC);
   assign last = (k_q == LAST_K);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) state_d = ISSUE;
         end
         ISSUE: begin
            if (fire && last) state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_slc = '0;
      b_slc = '0;
      for (int j = 0; j < WORDS; j++) begin
         if (k_q == KW'(j)) begin
            a_slc = a_q[16*j +: 16];
            b_slc = b_q[16*j +: 16];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         res_q     <= '0;
         carry_n_q <= 1'b1;
         k_q       <= '0;
         w_q       <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  a_q       <= req_a;
                  b_q       <= req_b;
                  op_q      <= req_op;
                  carry_n_q <= ~req_cin;
                  k_q       <= '0;
                  w_q       <= '0;
               end
            end
            ISSUE: begin
               if (!fire) begin
                  w_q <= w_q + 3'd1;
               end else begin
                  for (int j = 0; j < WORDS; j++) begin
                     if (k_q == KW'(j)) begin
                        res_q[16*j +: 16] <= alu_result;
                     end
                  end
                  carry_n_q <= alu_cout_n;
                  w_q       <= '0;
                  if (!last) k_q <= k_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_mode  = 1'b0;
      alu_sel   = '0;
      alu_cin_n = 1'b1;
      unique case (1'b1)
         (state_q == IDLE): begin
            req_ready = 1'b1;
         end
         (state_q == ISSUE): begin
            busy      = 1'b1;
            alu_a     = a_slc;
            alu_b     = b_slc;
            alu_mode  = op_q[4];
            alu_sel   = op_q[3:0];
            alu_cin_n = carry_n_q;
         end
         (state_q == RESP): begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign rsp_result = res_q;
   assign rsp_cout   = ~carry_n_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// tb_alu_slice_sequencer: two sequencers (settle 0 and 2)
// against a wide-arithmetic reference model.

module tb_alu_slice_sequencer;

   localparam int W  = 2;
   localparam int DW = 32;
   localparam logic [4:0] OP_ADD = 5'b0_1001;
   localparam logic [4:0] OP_SUB = 5'b0_0110;
   localparam logic [4:0] OP_XOR = 5'b1_0110;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic          req_valid [2];
   logic          req_ready [2];
   logic [DW-1:0] req_a [2];
   logic [DW-1:0] req_b [2];
   logic [4:0]    req_op [2];
   logic          req_cin [2];
   logic          rsp_valid [2];
   logic          rsp_ready [2];
   logic [DW-1:0] rsp_result [2];
   logic          rsp_cout [2];
   logic          busy [2];
   logic [15:0]   alu_a [2];
   logic [15:0]   alu_b [2];
   logic [15:0]   alu_result [2];
   logic          alu_mode [2];
   logic [3:0]    alu_sel [2];
   logic          alu_cin_n [2];
   logic          alu_cout_n [2];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;
   logic cin_tr [64];

   always #5 clk = ~clk;

   function automatic int settle(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   function automatic int lat(input int i);
      return W * (settle(i) + 1);
   endfunction

   // 74181-style ALU stub: returns {cout_n, result}
   function automatic logic [16:0] alu_f(
      input logic [15:0] a, input logic [15:0] b,
      input logic m, input logic [3:0] s, input logic cn);
      logic [15:0] t1, t2;
      logic [16:0] sum;
      t1 = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
      t2 = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
      if (m) return {1'b1, ~(t1 ^ t2)};
      sum = {1'b0, t1} + {1'b0, t2} + {16'd0, ~cn};
      return {~sum[16], sum[15:0]};
   endfunction

   // whole-width reference: {cout, result}
   function automatic logic [32:0] wide(
      input logic [31:0] a, input logic [31:0] b,
      input logic [4:0] op, input logic cin);
      logic [31:0] t1, t2;
      t1 = a | (b & {32{op[0]}}) | (~b & {32{op[1]}});
      t2 = (a & ~b & {32{op[2]}}) | (a & b & {32{op[3]}});
      if (op[4]) return {1'b0, ~(t1 ^ t2)};
      return {1'b0, t1} + {1'b0, t2} + {32'd0, cin};
   endfunction

   // active-low carry entering slice s
   function automatic logic exp_cin_n(
      input logic [31:0] a, input logic [31:0] b,
      input logic [4:0] op, input logic cin, input int s);
      logic [31:0] t1, t2;
      logic [63:0] mask, lo, sh;
      if (s > 0 && op[4]) return 1'b1;
      t1 = a | (b & {32{op[0]}}) | (~b & {32{op[1]}});
      t2 = (a & ~b & {32{op[2]}}) | (a & b & {32{op[3]}});
      mask = (64'd1 << (16 * s)) - 64'd1;
      lo = ({32'd0, t1} & mask) + ({32'd0, t2} & mask) + {63'd0, cin};
      sh = lo >> (16 * s);
      return ~sh[0];
   endfunction

   function automatic logic [15:0] sl(input logic [31:0] v, input int s);
      logic [31:0] t;
      t = v >> (16 * s);
      return t[15:0];
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      alu_slice_sequencer #(
         .WORDS(W),
         .SETTLE_CYCLES(g * 2)
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .req_valid(req_valid[g]),
         .req_ready(req_ready[g]),
         .req_a(req_a[g]),
         .req_b(req_b[g]),
         .req_op(req_op[g]),
         .req_cin(req_cin[g]),
         .rsp_valid(rsp_valid[g]),
         .rsp_ready(rsp_ready[g]),
         .rsp_result(rsp_result[g]),
         .rsp_cout(rsp_cout[g]),
         .busy(busy[g]),
         .alu_a(alu_a[g]),
         .alu_b(alu_b[g]),
         .alu_mode(alu_mode[g]),
         .alu_sel(alu_sel[g]),
         .alu_cin_n(alu_cin_n[g]),
         .alu_result(alu_result[g]),
         .alu_cout_n(alu_cout_n[g])
      );
      assign {alu_cout_n[g], alu_result[g]} = alu_f(
         alu_a[g], alu_b[g], alu_mode[g], alu_sel[g], alu_cin_n[g]);
   end

   // reference model: idle / counting down / holding response
   logic          m_ready [2];
   logic          m_valid [2];
   logic          m_cout [2];
   logic          p_cout [2];
   logic          m_cin [2];
   int            m_cnt [2];
   logic [DW-1:0] m_res [2];
   logic [DW-1:0] p_res [2];
   logic [DW-1:0] m_a [2];
   logic [DW-1:0] m_b [2];
   logic [4:0]    m_op [2];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_ready[i] <= 1'b1;
            m_valid[i] <= 1'b0;
            m_cnt[i]   <= 0;
            m_res[i]   <= '0;
            m_cout[i]  <= 1'b0;
         end else if (m_ready[i]) begin
            if (req_valid[i]) begin
               m_ready[i] <= 1'b0;
               m_cnt[i]   <= lat(i);
               m_a[i]     <= req_a[i];
               m_b[i]     <= req_b[i];
               m_op[i]    <= req_op[i];
               m_cin[i]   <= req_cin[i];
               {p_cout[i], p_res[i]} <= wide(req_a[i], req_b[i],
                                             req_op[i], req_cin[i]);
            end
         end else if (m_cnt[i] > 0) begin
            m_cnt[i] <= m_cnt[i] - 1;
            if (m_cnt[i] == 1) begin
               m_valid[i] <= 1'b1;
               m_res[i]   <= p_res[i];
               m_cout[i]  <= p_cout[i];
            end
         end else if (m_valid[i] && rsp_ready[i]) begin
            m_valid[i] <= 1'b0;
            m_ready[i] <= 1'b1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp_all();
      int s;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("d%0d req_ready", i), req_ready[i], m_ready[i]);
         chk($sformatf("d%0d busy", i), busy[i], !m_ready[i]);
         chk($sformatf("d%0d rsp_valid", i), rsp_valid[i], m_valid[i]);
         if (m_ready[i] || m_valid[i]) begin
            chk($sformatf("d%0d rsp_result", i), rsp_result[i], m_res[i]);
            chk($sformatf("d%0d rsp_cout", i), rsp_cout[i], m_cout[i]);
            chk($sformatf("d%0d alu_idle", i),
                {alu_a[i], alu_b[i], alu_mode[i], alu_sel[i],
                 alu_cin_n[i]},
                {16'h0, 16'h0, 1'b0, 4'h0, 1'b1});
         end else begin
            s = (lat(i) - m_cnt[i]) / (settle(i) + 1);
            chk($sformatf("d%0d alu_a s%0d", i, s), alu_a[i], sl(m_a[i], s));
            chk($sformatf("d%0d alu_b s%0d", i, s), alu_b[i], sl(m_b[i], s));
            chk($sformatf("d%0d alu_op", i),
                {alu_mode[i], alu_sel[i]}, m_op[i]);
            chk($sformatf("d%0d alu_cin_n s%0d", i, s), alu_cin_n[i],
                exp_cin_n(m_a[i], m_b[i], m_op[i], m_cin[i], s));
         end
      end
   endtask

   task automatic send(input int i, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] op,
                       input logic c);
      int n = 0;
      while (!req_ready[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("d%0d ready_wait", i), 64'(n < 50), 64'd1);
      req_a[i]     = a;
      req_b[i]     = b;
      req_op[i]    = op;
      req_cin[i]   = c;
      req_valid[i] = 1'b1;
      @(negedge clk);
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_rsp(input int i, input logic [31:0] er,
                           input logic ec, input string nm);
      int n = 0;
      while (!rsp_valid[i] && n < 40) begin
         cin_tr[n] = alu_cin_n[i];
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, 64'(n), 64'(lat(i)));
      chk({nm, " result"}, rsp_result[i], er);
      chk({nm, " cout"}, rsp_cout[i], ec);
   endtask

   task automatic ack(input int i);
      rsp_ready[i] = 1'b1;
      @(negedge clk);
      rsp_ready[i] = 1'b0;
   endtask

   initial begin
      bit seen;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_a[i]     = '0;
         req_b[i]     = '0;
         req_op[i]    = '0;
         req_cin[i]   = 1'b0;
         rsp_ready[i] = 1'b0;
      end
      fork
         forever begin
            @(negedge clk);
            if (chk_en) cmp_all();
         end
      join_none

      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("d%0d rst ready", i), req_ready[i], 1'b1);
         chk($sformatf("d%0d rst valid", i), rsp_valid[i], 1'b0);
         chk($sformatf("d%0d rst busy", i), busy[i], 1'b0);
         chk($sformatf("d%0d rst result", i), rsp_result[i], 32'h0);
         chk($sformatf("d%0d rst cin_n", i), alu_cin_n[i], 1'b1);
      end
      chk_en = 1'b1;
      rst_n  = 1'b1;
      @(negedge clk);

      send(0, 32'h0000_FFFF, 32'h0000_0001, OP_ADD, 1'b0);
      wait_rsp(0, 32'h0001_0000, 1'b0, "t1_add");
      chk("t1 cin_n s0", cin_tr[0], 1'b1);
      chk("t1 cin_n s1", cin_tr[1], 1'b0);
      ack(0);

      send(0, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0);
      wait_rsp(0, 32'h0000_0000, 1'b1, "t2_add_wrap");
      ack(0);

      send(0, 32'h0001_0000, 32'h0000_0001, OP_SUB, 1'b1);
      wait_rsp(0, 32'h0000_FFFF, 1'b1, "t3_sub");
      ack(0);

      send(0, 32'hDEAD_BEEF, 32'hBEEF_DEAD, OP_XOR, 1'b0);
      wait_rsp(0, 32'h6042_6042, 1'b0, "t4_xor");
      ack(0);

      send(0, 32'h0000_00FF, 32'h0000_0001, OP_ADD, 1'b0);
      wait_rsp(0, 32'h0000_0100, 1'b0, "t5_bp");
      for (int k = 0; k < 5; k++) begin
         req_valid[0] = (k % 2 == 0);
         req_a[0]     = $urandom;
         req_b[0]     = $urandom;
         req_op[0]    = OP_ADD;
         @(negedge clk);
         chk("t5 hold valid", rsp_valid[0], 1'b1);
         chk("t5 hold result", rsp_result[0], 32'h0000_0100);
         chk("t5 hold cout", rsp_cout[0], 1'b0);
         chk("t5 hold ready", req_ready[0], 1'b0);
      end
      req_a[0]     = 32'hF0F0_0F0F;
      req_b[0]     = 32'h0FF0_0FF0;
      req_op[0]    = OP_XOR;
      req_cin[0]   = 1'b0;
      req_valid[0] = 1'b1;
      rsp_ready[0] = 1'b1;
      @(negedge clk);
      rsp_ready[0] = 1'b0;
      chk("t5 valid drop", rsp_valid[0], 1'b0);
      chk("t5 ready rise", req_ready[0], 1'b1);
      @(negedge clk);
      chk("t5 held accept", req_ready[0], 1'b0);
      chk("t5 held busy", busy[0], 1'b1);
      req_valid[0] = 1'b0;
      wait_rsp(0, 32'hFF00_00FF, 1'b0, "t5_held");
      ack(0);

      send(1, 32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b0);
      wait_rsp(1, 32'h2345_6789, 1'b0, "t6_settle");
      ack(1);

      send(1, 32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b0);
      repeat (3) @(negedge clk);
      chk("t6 slice1 a", alu_a[1], 16'h1234);
      #2 rst_n = 1'b0;
      #1;
      chk("t6 rst ready", req_ready[1], 1'b1);
      chk("t6 rst valid", rsp_valid[1], 1'b0);
      chk("t6 rst busy", busy[1], 1'b0);
      chk("t6 rst result", rsp_result[1], 32'h0);
      chk("t6 rst cout", rsp_cout[1], 1'b0);
      chk("t6 rst alu",
          {alu_a[1], alu_b[1], alu_mode[1], alu_sel[1], alu_cin_n[1]},
          {16'h0, 16'h0, 1'b0, 4'h0, 1'b1});
      @(negedge clk);
      #2 rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid[1]) seen = 1'b1;
      end
      chk("t6 no rsp", seen, 1'b0);
      chk("t6 ready after", req_ready[1], 1'b1);

      repeat (3000) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            req_valid[i] = ($urandom_range(0, 2) != 0);
            req_a[i]     = $urandom;
            req_b[i]     = $urandom;
            req_op[i]    = 5'($urandom);
            req_cin[i]   = 1'($urandom);
            rsp_ready[i] = 1'($urandom_range(0, 1));
         end
      end
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
